// File: rtl/superscalar_pkg.sv
// Shared ROB configuration: default sizing, tag-width derivation, entry payload layout.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package superscalar_pkg;

  localparam int ROB_DEPTH    = 16;
  localparam int ROB_DISP_W   = 2;
  localparam int ROB_COMMIT_W = 2;
  localparam int ROB_CDB_N    = 2;

  // Tag is the entry index; keep at least one bit for degenerate sizes.
  function automatic int rob_tag_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Payload layout (valid/done live in separate reset-able flag vectors):
  // {target, data, dest, mispred, branch, store, wr}
  localparam int ENT_WR      = 0;
  localparam int ENT_STORE   = 1;
  localparam int ENT_BRANCH  = 2;
  localparam int ENT_MISPRED = 3;
  localparam int ENT_DEST    = 4;

  function automatic int ent_data_lsb(input int reg_w);
    return ENT_DEST + reg_w;
  endfunction

  function automatic int ent_target_lsb(input int reg_w, input int data_w);
    return ENT_DEST + reg_w + data_w;
  endfunction

  function automatic int ent_w(input int reg_w, input int data_w, input int pc_w);
    return ENT_DEST + reg_w + data_w + pc_w;
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Picks the in-order prefix of retiring slots at the ROB head.
// Latency: combinational.
// Backpressure: none; stops at the first not-done slot or just after a mispredicted branch.
module rob_commit_sel
  import superscalar_pkg::*;
#(
  parameter int COMMIT_W = ROB_COMMIT_W,
  parameter int CNT_W    = 2
) (
  input  logic [COMMIT_W-1:0] slot_valid,
  input  logic [COMMIT_W-1:0] slot_done,
  input  logic [COMMIT_W-1:0] slot_mispred,
  output logic [COMMIT_W-1:0] commit_mask,
  output logic [CNT_W-1:0]    commit_cnt,
  output logic                recover
);

  // Walk slots oldest-first; a gap or a retiring mispredict closes the window.
  always_comb begin
    logic run;
    run         = 1'b1;
    commit_mask = '0;
    commit_cnt  = '0;
    recover     = 1'b0;
    for (int j = 0; j < COMMIT_W; j++) begin
      if (run && slot_valid[j] && slot_done[j]) begin
        commit_mask[j] = 1'b1;
        commit_cnt     = commit_cnt + CNT_W'(1);
        if (slot_mispred[j]) begin
          recover = 1'b1;
          run     = 1'b0;
        end
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation at dispatch, CDB snoop, in-order retirement, mispredict flush.
// Latency: CDB completion retires no earlier than the next cycle; flush/redirect one cycle after the branch retires.
// Backpressure: disp_ready drops when fewer than DISP_W entries are free or during flush; group must be held.
// Optional build macro ROB_PERF_CNT_EN adds saturating perf_commits/perf_flushes/perf_full_stalls ports.
module reorder_buffer
  import superscalar_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int TAG_W    = rob_tag_w(DEPTH),
  parameter int DISP_W   = ROB_DISP_W,
  parameter int COMMIT_W = ROB_COMMIT_W,
  parameter int CDB_N    = ROB_CDB_N,
  parameter int DATA_W   = 16,
  parameter int REG_W    = 5,
  parameter int PC_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DISP_W-1:0]          disp_valid,
  input  logic [DISP_W*REG_W-1:0]    disp_dest,
  input  logic [DISP_W-1:0]          disp_wr,
  input  logic [DISP_W-1:0]          disp_store,
  input  logic [DISP_W-1:0]          disp_branch,
  output logic                       disp_ready,
  output logic [DISP_W*TAG_W-1:0]    disp_tag,
  input  logic [CDB_N-1:0]           cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]     cdb_tag,
  input  logic [CDB_N*DATA_W-1:0]    cdb_data,
  input  logic [CDB_N-1:0]           cdb_mispred,
  input  logic [CDB_N*PC_W-1:0]      cdb_target,
  output logic [COMMIT_W-1:0]        commit_valid,
  output logic [COMMIT_W*REG_W-1:0]  commit_dest,
  output logic [COMMIT_W*DATA_W-1:0] commit_data,
  output logic [COMMIT_W-1:0]        commit_wr,
  output logic [COMMIT_W-1:0]        commit_store,
  output logic                       flush,
  output logic [PC_W-1:0]            redirect_pc,
  output logic [TAG_W:0]             rob_count,
  output logic                       rob_empty
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                perf_commits,
  output logic [31:0]                perf_flushes,
  output logic [31:0]                perf_full_stalls
`endif
);

  localparam int ENT_BITS = ent_w(REG_W, DATA_W, PC_W);
  localparam int DATA_LSB = ent_data_lsb(REG_W);
  localparam int TGT_LSB  = ent_target_lsb(REG_W, DATA_W);
  // Highest occupancy at which a full group still fits.
  localparam logic [TAG_W:0] FILL_MAX = (TAG_W+1)'(DEPTH - DISP_W);

  logic [TAG_W-1:0]    head_q, tail_q;
  logic [TAG_W:0]      count_q;
  logic [DEPTH-1:0]    valid_q, done_q;
  logic [ENT_BITS-1:0] ent_q [DEPTH];
  logic                flush_q;
  logic [PC_W-1:0]     redirect_q;

  logic                disp_fire;
  logic [TAG_W:0]      disp_cnt, acc_cnt;
  logic [TAG_W-1:0]    slot_tag [DISP_W];

  logic [TAG_W-1:0]    hidx [COMMIT_W];
  logic [COMMIT_W-1:0] head_valid, head_done, head_mispred;
  logic [COMMIT_W-1:0] commit_mask;
  logic [TAG_W:0]      commit_cnt;
  logic                recover;
  logic [PC_W-1:0]     redirect_next;

  // Admission uses occupancy before this cycle's retirements, so it is conservative.
  assign disp_ready = (count_q <= FILL_MAX) && !flush_q;
  assign disp_fire  = disp_ready && (|disp_valid);
  assign acc_cnt    = disp_fire ? disp_cnt : '0;

  // Compact valid dispatch slots onto consecutive tags starting at tail.
  always_comb begin
    disp_cnt = '0;
    disp_tag = '0;
    for (int i = 0; i < DISP_W; i++) begin
      slot_tag[i] = tail_q + disp_cnt[TAG_W-1:0];
      disp_tag[i*TAG_W +: TAG_W] = slot_tag[i];
      if (disp_valid[i]) disp_cnt = disp_cnt + (TAG_W+1)'(1);
    end
  end

  // Gather status of the COMMIT_W oldest entries; only branches can mispredict.
  always_comb begin
    for (int j = 0; j < COMMIT_W; j++) begin
      hidx[j]         = head_q + TAG_W'(j);
      head_valid[j]   = valid_q[hidx[j]];
      head_done[j]    = done_q[hidx[j]];
      head_mispred[j] = ent_q[hidx[j]][ENT_MISPRED] & ent_q[hidx[j]][ENT_BRANCH];
    end
  end

  rob_commit_sel #(
    .COMMIT_W (COMMIT_W),
    .CNT_W    (TAG_W + 1)
  ) u_commit_sel (
    .slot_valid   (head_valid),
    .slot_done    (head_done),
    .slot_mispred (head_mispred),
    .commit_mask  (commit_mask),
    .commit_cnt   (commit_cnt),
    .recover      (recover)
  );

  // Drive retirement ports; payload is zeroed on idle slots so nothing stale leaks out.
  always_comb begin
    commit_valid  = commit_mask;
    commit_dest   = '0;
    commit_data   = '0;
    commit_wr     = '0;
    commit_store  = '0;
    redirect_next = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      if (commit_mask[j]) begin
        commit_dest[j*REG_W +: REG_W]   = ent_q[hidx[j]][ENT_DEST +: REG_W];
        commit_data[j*DATA_W +: DATA_W] = ent_q[hidx[j]][DATA_LSB +: DATA_W];
        commit_wr[j]                    = ent_q[hidx[j]][ENT_WR];
        commit_store[j]                 = ent_q[hidx[j]][ENT_STORE];
        if (head_mispred[j]) redirect_next = ent_q[hidx[j]][TGT_LSB +: PC_W];
      end
    end
  end

  // Pointers, occupancy and valid/done flags; a retiring mispredict empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      flush_q <= recover;
      if (recover) redirect_q <= redirect_next;
      if (recover) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        valid_q <= '0;
        done_q  <= '0;
      end else begin
        for (int p = 0; p < CDB_N; p++) begin
          if (cdb_valid[p] && valid_q[cdb_tag[p*TAG_W +: TAG_W]])
            done_q[cdb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
        end
        for (int i = 0; i < DISP_W; i++) begin
          if (disp_fire && disp_valid[i]) begin
            valid_q[slot_tag[i]] <= 1'b1;
            done_q[slot_tag[i]]  <= 1'b0;
          end
        end
        for (int j = 0; j < COMMIT_W; j++) begin
          if (commit_mask[j]) begin
            valid_q[hidx[j]] <= 1'b0;
            done_q[hidx[j]]  <= 1'b0;
          end
        end
        head_q  <= head_q + commit_cnt[TAG_W-1:0];
        tail_q  <= tail_q + acc_cnt[TAG_W-1:0];
        count_q <= count_q + acc_cnt - commit_cnt;
      end
    end
  end

  // Entry payload: written at allocation, then updated by CDB (higher port wins on a tie).
  always_ff @(posedge clk) begin
    for (int i = 0; i < DISP_W; i++) begin
      if (disp_fire && disp_valid[i]) begin
        ent_q[slot_tag[i]][ENT_WR]              <= disp_wr[i];
        ent_q[slot_tag[i]][ENT_STORE]           <= disp_store[i];
        ent_q[slot_tag[i]][ENT_BRANCH]          <= disp_branch[i];
        ent_q[slot_tag[i]][ENT_MISPRED]         <= 1'b0;
        ent_q[slot_tag[i]][ENT_DEST +: REG_W]   <= disp_dest[i*REG_W +: REG_W];
      end
    end
    for (int p = 0; p < CDB_N; p++) begin
      if (cdb_valid[p] && valid_q[cdb_tag[p*TAG_W +: TAG_W]]) begin
        ent_q[cdb_tag[p*TAG_W +: TAG_W]][ENT_MISPRED]        <= cdb_mispred[p];
        ent_q[cdb_tag[p*TAG_W +: TAG_W]][DATA_LSB +: DATA_W] <= cdb_data[p*DATA_W +: DATA_W];
        ent_q[cdb_tag[p*TAG_W +: TAG_W]][TGT_LSB +: PC_W]    <= cdb_target[p*PC_W +: PC_W];
      end
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign rob_count   = count_q;
  assign rob_empty   = (count_q == '0);

`ifdef ROB_PERF_CNT_EN
  // Saturating event counters: retired instructions, recoveries, blocked dispatch cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_commits     <= '0;
      perf_flushes     <= '0;
      perf_full_stalls <= '0;
    end else begin
      if (perf_commits > (32'hFFFF_FFFF - 32'(commit_cnt))) perf_commits <= '1;
      else perf_commits <= perf_commits + 32'(commit_cnt);
      if (recover && (perf_flushes != '1)) perf_flushes <= perf_flushes + 32'd1;
      if ((|disp_valid) && !disp_ready && (perf_full_stalls != '1))
        perf_full_stalls <= perf_full_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer (DEPTH=16, 2-wide dispatch/commit, 2 CDB ports).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
// Summary line reports passed/total comparisons.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  disp_valid, disp_wr, disp_store, disp_branch;
  logic [9:0]  disp_dest;
  logic        disp_ready;
  logic [7:0]  disp_tag;
  logic [1:0]  cdb_valid, cdb_mispred;
  logic [7:0]  cdb_tag;
  logic [31:0] cdb_data, cdb_target;
  logic [1:0]  commit_valid, commit_wr, commit_store;
  logic [9:0]  commit_dest;
  logic [31:0] commit_data;
  logic        flush;
  logic [15:0] redirect_pc;
  logic [4:0]  rob_count;
  logic        rob_empty;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .disp_valid   (disp_valid),
    .disp_dest    (disp_dest),
    .disp_wr      (disp_wr),
    .disp_store   (disp_store),
    .disp_branch  (disp_branch),
    .disp_ready   (disp_ready),
    .disp_tag     (disp_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_mispred  (cdb_mispred),
    .cdb_target   (cdb_target),
    .commit_valid (commit_valid),
    .commit_dest  (commit_dest),
    .commit_data  (commit_data),
    .commit_wr    (commit_wr),
    .commit_store (commit_store),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .rob_count    (rob_count),
    .rob_empty    (rob_empty)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_cdb();
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0; cdb_mispred = '0; cdb_target = '0;
  endtask

  task automatic clear_inputs();
    disp_valid = '0; disp_dest = '0; disp_wr = '0; disp_store = '0; disp_branch = '0;
    clear_cdb();
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_disp(input logic [1:0] v, input logic [4:0] d0, input logic [4:0] d1,
                            input logic [1:0] wr, input logic [1:0] st, input logic [1:0] br);
    disp_valid = v; disp_dest = {d1, d0}; disp_wr = wr; disp_store = st; disp_branch = br;
  endtask

  task automatic drive_cdb(input int p, input logic [3:0] tag, input logic [15:0] data,
                           input logic mis, input logic [15:0] tgt);
    cdb_valid[p] = 1'b1;
    cdb_tag[p*4 +: 4] = tag;
    cdb_data[p*16 +: 16] = data;
    cdb_mispred[p] = mis;
    cdb_target[p*16 +: 16] = tgt;
  endtask

  task automatic pulse_rst();
    rst = 1'b1; #2; rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    #12;
    check("rst_ready", disp_ready, 1);
    check("rst_empty", rob_empty, 1);
    check("rst_count", rob_count, 0);
    check("rst_flush", flush, 0);
    check("rst_redirect", redirect_pc, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_commit_data", commit_data, 0);
    tick();
    rst = 1'b0;

    // 1: out-of-order completion, in-order retire
    drive_disp(2'b11, 5'd3, 5'd4, 2'b11, 2'b00, 2'b00);
    #1 check("t1_tag", disp_tag, 8'h10);
    tick(); clear_inputs();
    #1 check("t1_count", rob_count, 2);
    drive_cdb(0, 4'd1, 16'h0055, 1'b0, 16'h0);
    tick(); clear_inputs();
    #1 check("t1_head_not_done", commit_valid, 2'b00);
    drive_cdb(0, 4'd0, 16'h0011, 1'b0, 16'h0);
    #1 check("t1_no_bypass", commit_valid, 2'b00);
    tick(); clear_inputs();
    #1 check("t1_commit_valid", commit_valid, 2'b11);
    check("t1_commit_dest", commit_dest, 10'h083);
    check("t1_commit_data", commit_data, 32'h0055_0011);
    check("t1_commit_wr", commit_wr, 2'b11);
    check("t1_commit_store", commit_store, 2'b00);
    tick();
    #1 check("t1_count_after", rob_count, 0);
    check("t1_empty_after", rob_empty, 1);

    // 2: fill to DEPTH, hold, wrap
    pulse_rst();
    for (int p = 0; p < 8; p++) begin
      drive_disp(2'b11, 5'(2*p), 5'(2*p+1), 2'b11, 2'b00, 2'b00);
      #1 check("t2_fill_tag", disp_tag, {4'(2*p+1), 4'(2*p)});
      tick(); clear_inputs();
    end
    #1 check("t2_full_count", rob_count, 16);
    check("t2_full_ready", disp_ready, 0);
    drive_disp(2'b11, 5'd30, 5'd31, 2'b11, 2'b00, 2'b00);
    drive_cdb(0, 4'd0, 16'h00A0, 1'b0, 16'h0);
    drive_cdb(1, 4'd1, 16'h00A1, 1'b0, 16'h0);
    tick(); clear_cdb();
    #1 check("t2_held_count", rob_count, 16);
    check("t2_commit_valid", commit_valid, 2'b11);
    check("t2_commit_data", commit_data, 32'h00A1_00A0);
    check("t2_still_blocked", disp_ready, 0);
    tick();
    #1 check("t2_count_after_commit", rob_count, 14);
    check("t2_ready_again", disp_ready, 1);
    check("t2_wrap_tag", disp_tag, 8'h10);
    tick(); clear_inputs();
    #1 check("t2_refill_count", rob_count, 16);

    // 3: mispredicted branch at tag 2
    pulse_rst();
    drive_disp(2'b11, 5'd1, 5'd2, 2'b11, 2'b00, 2'b00); tick();
    drive_disp(2'b11, 5'd0, 5'd3, 2'b10, 2'b00, 2'b01); tick();
    drive_disp(2'b11, 5'd4, 5'd5, 2'b11, 2'b00, 2'b00); tick(); clear_inputs();
    drive_cdb(0, 4'd0, 16'h0100, 1'b0, 16'h0);
    drive_cdb(1, 4'd1, 16'h0101, 1'b0, 16'h0);
    tick(); clear_inputs();
    #1 check("t3_commit01", commit_valid, 2'b11);
    drive_cdb(0, 4'd3, 16'h0103, 1'b0, 16'h0);
    drive_cdb(1, 4'd4, 16'h0104, 1'b0, 16'h0);
    tick(); clear_inputs();
    #1 check("t3_wait_branch", commit_valid, 2'b00);
    check("t3_count4", rob_count, 4);
    drive_cdb(0, 4'd5, 16'h0105, 1'b0, 16'h0);
    drive_cdb(1, 4'd2, 16'h0000, 1'b1, 16'h0040);
    tick(); clear_inputs();
    #1 check("t3_branch_only", commit_valid, 2'b01);
    check("t3_no_flush_yet", flush, 0);
    drive_disp(2'b11, 5'd6, 5'd7, 2'b11, 2'b00, 2'b00);
    tick(); clear_inputs();
    #1 check("t3_flush", flush, 1);
    check("t3_redirect", redirect_pc, 16'h0040);
    check("t3_count_flushed", rob_count, 0);
    check("t3_ready_low", disp_ready, 0);
    check("t3_no_commit", commit_valid, 2'b00);
    tick();
    #1 check("t3_flush_done", flush, 0);
    check("t3_ready_back", disp_ready, 1);
    check("t3_empty", rob_empty, 1);

    // 4: store retire, CDB same-tag priority
    drive_disp(2'b11, 5'd0, 5'd7, 2'b10, 2'b01, 2'b00); tick();
    drive_disp(2'b11, 5'd8, 5'd9, 2'b11, 2'b00, 2'b00); tick();
    drive_disp(2'b11, 5'd10, 5'd11, 2'b11, 2'b00, 2'b00); tick(); clear_inputs();
    drive_cdb(0, 4'd0, 16'h0000, 1'b0, 16'h0);
    tick(); clear_inputs();
    #1 check("t4_store_valid", commit_valid, 2'b01);
    check("t4_store", commit_store, 2'b01);
    check("t4_store_wr", commit_wr, 2'b00);
    drive_cdb(0, 4'd5, 16'h0007, 1'b0, 16'h0);
    drive_cdb(1, 4'd5, 16'h0009, 1'b0, 16'h0);
    tick(); clear_inputs();
    drive_cdb(0, 4'd1, 16'h0071, 1'b0, 16'h0);
    drive_cdb(1, 4'd2, 16'h0072, 1'b0, 16'h0);
    tick(); clear_inputs();
    #1 check("t4_c12_data", commit_data, 32'h0072_0071);
    check("t4_c12_dest", commit_dest, {5'd8, 5'd7});
    drive_cdb(0, 4'd3, 16'h0073, 1'b0, 16'h0);
    drive_cdb(1, 4'd4, 16'h0074, 1'b0, 16'h0);
    tick(); clear_inputs();
    #1 check("t4_c34_valid", commit_valid, 2'b11);
    tick();
    #1 check("t4_c5_valid", commit_valid, 2'b01);
    check("t4_c5_data_port1_wins", commit_data, 32'h0000_0009);
    check("t4_c5_dest", commit_dest, {5'd0, 5'd11});
    tick();
    #1 check("t4_empty", rob_count, 0);

    // 5: asynchronous reset while a flush is pending
    drive_disp(2'b01, 5'd12, 5'd0, 2'b00, 2'b00, 2'b01);
    #1 check("t5_tag", disp_tag[3:0], 4'd6);
    tick(); clear_inputs();
    drive_cdb(0, 4'd6, 16'h0000, 1'b1, 16'h0080);
    tick(); clear_inputs();
    #1 check("t5_branch_commit", commit_valid, 2'b01);
    #1 rst = 1'b1;
    #1 check("t5_async_commit", commit_valid, 2'b00);
    check("t5_async_count", rob_count, 0);
    tick();
    #1 check("t5_flush_cancelled", flush, 0);
    check("t5_redirect", redirect_pc, 0);
    check("t5_ready", disp_ready, 1);
    check("t5_empty", rob_empty, 1);
    rst = 1'b0;

    // 6: sparse dispatch group compacts onto tail
    drive_disp(2'b10, 5'd0, 5'd13, 2'b10, 2'b00, 2'b00);
    #1 check("t6_slot1_tag", disp_tag[7:4], 4'd0);
    tick(); clear_inputs();
    #1 check("t6_count1", rob_count, 1);
    drive_disp(2'b11, 5'd14, 5'd15, 2'b11, 2'b00, 2'b00);
    #1 check("t6_next_tags", disp_tag, 8'h21);
    tick(); clear_inputs();
    #1 check("t6_count3", rob_count, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Parametrised circular reorder buffer for the dual-issue out-of-order core. It replaces the immediate CDB-to-ARF writeback with tagged, in-order retirement. It sits between dispatch (tag allocation) and the architectural register file / store path (commit), and snoops N CDB slots for completions. It also provides precise recovery: a mispredicted branch flushes the buffer and redirects the PC when that branch retires.

Parameters:
DEPTH, 16, number of entries; must be a power of 2, minimum 4.
TAG_W, $clog2(DEPTH), width of the ROB tag (entry index).
DISP_W, 2, instructions allocated per cycle.
COMMIT_W, 2, instructions retired per cycle.
CDB_N, 2, CDB broadcast slots snooped per cycle.
DATA_W, 16, result data width.
REG_W, 5, architectural register index width.
PC_W, 16, redirect target width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
disp_valid  in  DISP_W  per-slot allocate request; slot 0 is oldest
disp_dest  in  DISP_W*REG_W  destination register, slot i at [i*REG_W +: REG_W]
disp_wr  in  DISP_W  instruction writes a register
disp_store  in  DISP_W  instruction is a store
disp_branch  in  DISP_W  instruction is a branch
disp_ready  out  1  ROB can accept the full dispatch group this cycle
disp_tag  out  DISP_W*TAG_W  tag assigned to each valid slot
cdb_valid  in  CDB_N  completion broadcast valid
cdb_tag  in  CDB_N*TAG_W  completing entry
cdb_data  in  CDB_N*DATA_W  result data
cdb_mispred  in  CDB_N  branch resolved opposite to its prediction
cdb_target  in  CDB_N*PC_W  correct PC for a mispredicted branch
commit_valid  out  COMMIT_W  entry retires at this clock edge; slot 0 is oldest
commit_dest  out  COMMIT_W*REG_W  ARF write index
commit_data  out  COMMIT_W*DATA_W  ARF write data
commit_wr  out  COMMIT_W  ARF write enable (commit_valid & wr)
commit_store  out  COMMIT_W  release the store buffer head
flush  out  1  one-cycle pipeline flush pulse
redirect_pc  out  PC_W  fetch target, valid while flush=1
rob_count  out  TAG_W+1  occupied entries
rob_empty  out  1  rob_count==0

Behaviour:
- Storage: head and tail pointers (TAG_W bits, wrap modulo DEPTH) plus count (TAG_W+1 bits). Each entry holds valid, done, dest, wr, store, branch, mispred, data, and target.
- Reset (asynchronous): head=tail=count=0, all valid/done cleared, flush=0, redirect_pc=0. Consequently disp_ready=1, commit_*=0, rob_empty=1.
- Dispatch:
  - disp_ready = (DEPTH-count >= DISP_W) & ~flush. The check uses count before this cycle's commits (conservative).
  - The group is accepted only when disp_ready=1; otherwise it is ignored and the front end must hold it.
  - Valid slots are compacted: the k-th valid slot receives tag tail+k. disp_tag is combinational from tail; the tag of an invalid slot is don't-care.
  - At the edge: entries are written with valid=1, done=0, and tail advances by popcount(disp_valid).
- CDB:
  - For each port with cdb_valid, the entry at cdb_tag gets done=1, data, mispred, and target.
  - A tag whose entry is not valid is ignored.
  - If two ports carry the same tag, the higher port index wins.
  - Completion is visible to commit the cycle after the broadcast; there is no same-cycle bypass.
- Commit (combinational from state):
  - Slot j is valid if entry head+j is valid and done, and every slot before it is committing, j<COMMIT_W. Commit stops at the first not-done entry.
  - A slot with mispred=1 commits, but all younger slots are suppressed in that cycle.
  - At the edge, head advances by the number of committed slots.
  - Empty ROB: all commit_valid=0.
- Mispredict recovery:
  - At the edge where a mispred branch commits, all entries are invalidated, head=tail=count=0, and any same-cycle dispatch is discarded.
  - Next cycle: flush=1 for exactly one cycle, redirect_pc=target, disp_ready=0. Normal operation resumes the cycle after.
- Count update: count_next = count + accepted - committed. Simultaneous dispatch and commit at full or wrap boundaries must be exact.
- rst mid-operation: immediate return to the reset state. A pending flush is cancelled.

Optional Feature:
ROB_PERF_CNT_EN: adds 32-bit saturating counters perf_commits, perf_flushes, and perf_full_stalls (cycles where disp_valid!=0 & ~disp_ready), output as ports. All three are cleared by rst. Without the macro, neither the ports nor the counters exist.

Decomposition:
- Shared package superscalar_pkg holds TAG_W derivation, default DEPTH/DISP_W/COMMIT_W/CDB_N, and the entry-field bit offsets.
- One sub-module, rob_commit_sel: combinational prefix selection of committing slots. It takes COMMIT_W done/valid/mispred bits at head and returns commit mask and retire count.

Test Plan:
1. Reset, then dispatch 2 instructions (dest r3, r4) -> disp_tag 0,1; rob_count=2. CDB tag1 data 0x0055 -> no commit (head not done). Then CDB tag0 data 0x0011 -> next cycle both commit: r3=0x0011, r4=0x0055; rob_count=0.
2. Fill DEPTH=16 with 8 pairs -> disp_ready=0 at count 16 and the 9th pair is held. Complete tags 0,1 -> commit 2; the held pair gets tags 0,1 after wrap.
3. Branch at tag 2 completes with cdb_mispred=1, target 0x0040; tags 3-5 done -> tags 0-2 commit, tag 3+ never commit. flush=1 one cycle later, redirect_pc=0x0040, rob_count=0.
4. Store at head done -> commit_store=1, commit_wr=0. Both CDB ports carry tag 5 with data 7 and 9 -> entry 5 holds 9.
5. Assert rst asynchronously in the cycle flush is pending -> flush stays 0; all outputs return to reset values.
6. Dispatch with disp_valid=2'b10 -> slot 1 receives tag=tail; tail advances by 1.
